display_timing_recovery: RTL and testbench

- Receive-side counterpart of the display timing generator. Consumes a raw hsync/vsync/de stream in the pixel clock domain.
- Recovers pixel coordinates, measures line/frame geometry, and declares lock once the geometry is stable across consecutive frames.
- Sits at the input of the capture/scaler path, or in loopback checking of the output timing path.

---
 rtl/display_timing_recovery.sv | 196 +++++++++++++++++++
 tb/tb_display_timing_recovery.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/display_timing_recovery.sv
// Receive-side timing recovery: rebuilds pixel coordinates from a raw hsync/vsync/de
// stream, measures line/frame geometry and declares lock once it is stable.
module display_timing_recovery #(
    parameter int CORDW       = 10,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk_pix,
    input  logic             rst_n,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             de,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             de_o,
    output logic             locked,
    output logic             err,
    output logic [CORDW-1:0] h_total,
    output logic [CORDW-1:0] v_total,
    output logic [CORDW-1:0] h_active,
    output logic [CORDW-1:0] v_active
);

    localparam logic [CORDW-1:0] CMAX = '1;
    localparam logic [CORDW-1:0] ONE  = CORDW'(1);
    localparam logic [3:0]       LF   = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_e;

    state_e           state_q, state_d;
    logic             hs_q, vs_q, de_q, hs_prev_q, vs_prev_q;
    logic             hs_fall, vs_fall, timeout, tuple_match;
    logic [CORDW-1:0] h_cnt_q, h_cnt_d, hs_cnt_q, hs_cnt_d;
    logic [CORDW-1:0] de_cnt_q, de_cnt_d, act_cnt_q, act_cnt_d;
    logic [CORDW-1:0] sx_hold_q, sx_hold_d, sy_q, sy_d, line_pos;
    logic             line_de_q, line_de_d;
    logic [CORDW-1:0] h_total_q, h_total_d, v_total_q, v_total_d;
    logic [CORDW-1:0] h_active_q, h_active_d, v_active_q, v_active_d;
    logic [CORDW-1:0] ref_h_q, ref_h_d, ref_v_q, ref_v_d;
    logic [CORDW-1:0] ref_ha_q, ref_ha_d, ref_va_q, ref_va_d;
    logic             ref_valid_q, ref_valid_d;
    logic [3:0]       match_q, match_d, match_inc;
    logic             err_q, err_d;

    function automatic logic [CORDW-1:0] sat_inc(input logic [CORDW-1:0] v);
        return (v == CMAX) ? v : v + ONE;
    endfunction

    assign hs_fall     = hs_prev_q & ~hs_q;
    assign vs_fall     = vs_prev_q & ~vs_q;
    assign timeout     = (h_cnt_q == CMAX);
    assign match_inc   = match_q + 4'd1;
    assign tuple_match = (h_total_d == ref_h_q) && (v_total_d == ref_v_q) &&
                         (h_active_d == ref_ha_q) && (v_active_d == ref_va_q);

    // The hsync-fall cycle already belongs to the new line, so sx restarts there.
    assign line_pos = hs_fall ? '0 : de_cnt_q;

    assign sx       = de_q ? line_pos : sx_hold_q;
    assign sy       = sy_q;
    assign de_o     = de_q;
    assign locked   = (state_q == LOCKED);
    assign err      = err_q;
    assign h_total  = h_total_q;
    assign v_total  = v_total_q;
    assign h_active = h_active_q;
    assign v_active = v_active_q;

    always_comb begin
        h_cnt_d    = hs_fall ? ONE : sat_inc(h_cnt_q);
        h_total_d  = hs_fall ? h_cnt_q : h_total_q;
        de_cnt_d   = de_q ? sat_inc(line_pos) : line_pos;
        sx_hold_d  = de_q ? line_pos : sx_hold_q;
        line_de_d  = hs_fall ? de_q : (line_de_q | de_q);
        h_active_d = (hs_fall && line_de_q) ? de_cnt_q : h_active_q;
        hs_cnt_d   = hs_cnt_q;
        sy_d       = sy_q;
        act_cnt_d  = act_cnt_q;
        v_total_d  = v_total_q;
        v_active_d = v_active_q;
        if (hs_fall) begin
            hs_cnt_d = sat_inc(hs_cnt_q);
            if (line_de_q) begin
                sy_d      = sat_inc(sy_q);
                act_cnt_d = sat_inc(act_cnt_q);
            end
        end
        // vsync fall overrides a coincident hsync fall; that hsync fall opens the new frame.
        if (vs_fall) begin
            v_total_d  = hs_cnt_q;
            v_active_d = act_cnt_q;
            hs_cnt_d   = hs_fall ? ONE : '0;
            sy_d       = '0;
            act_cnt_d  = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        match_d     = match_q;
        ref_valid_d = ref_valid_q;
        ref_h_d     = ref_h_q;
        ref_v_d     = ref_v_q;
        ref_ha_d    = ref_ha_q;
        ref_va_d    = ref_va_q;
        err_d       = 1'b0;
        case (state_q)
            SEARCH: begin
                if (vs_fall) begin
                    state_d     = VERIFY;
                    match_d     = '0;
                    ref_valid_d = 1'b0;
                end
            end
            VERIFY: begin
                if (timeout) begin
                    state_d = SEARCH;
                end else if (vs_fall) begin
                    if (ref_valid_q && tuple_match) begin
                        match_d = match_inc;
                        if (match_inc == LF) state_d = LOCKED;
                    end else begin
                        ref_valid_d = 1'b1;
                        match_d     = '0;
                        ref_h_d     = h_total_d;
                        ref_v_d     = v_total_d;
                        ref_ha_d    = h_active_d;
                        ref_va_d    = v_active_d;
                    end
                end
            end
            LOCKED: begin
                if (timeout || (hs_fall && (h_cnt_q != ref_h_q)) ||
                    (vs_fall && !tuple_match)) begin
                    state_d = SEARCH;
                    err_d   = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEARCH;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            hs_prev_q   <= 1'b1;
            vs_prev_q   <= 1'b1;
            de_q        <= 1'b0;
            h_cnt_q     <= '0;
            hs_cnt_q    <= '0;
            de_cnt_q    <= '0;
            act_cnt_q   <= '0;
            sx_hold_q   <= '0;
            sy_q        <= '0;
            line_de_q   <= 1'b0;
            h_total_q   <= '0;
            v_total_q   <= '0;
            h_active_q  <= '0;
            v_active_q  <= '0;
            ref_h_q     <= '0;
            ref_v_q     <= '0;
            ref_ha_q    <= '0;
            ref_va_q    <= '0;
            ref_valid_q <= 1'b0;
            match_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hs_q        <= hsync;
            vs_q        <= vsync;
            hs_prev_q   <= hs_q;
            vs_prev_q   <= vs_q;
            de_q        <= de;
            h_cnt_q     <= h_cnt_d;
            hs_cnt_q    <= hs_cnt_d;
            de_cnt_q    <= de_cnt_d;
            act_cnt_q   <= act_cnt_d;
            sx_hold_q   <= sx_hold_d;
            sy_q        <= sy_d;
            line_de_q   <= line_de_d;
            h_total_q   <= h_total_d;
            v_total_q   <= v_total_d;
            h_active_q  <= h_active_d;
            v_active_q  <= v_active_d;
            ref_h_q     <= ref_h_d;
            ref_v_q     <= ref_v_d;
            ref_ha_q    <= ref_ha_d;
            ref_va_q    <= ref_va_d;
            ref_valid_q <= ref_valid_d;
            match_q     <= match_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_display_timing_recovery.sv
// Bench for display_timing_recovery: scaled-down raster stream with randomized
// disturbances, checked every cycle against a frame-level reference model.
module tb_display_timing_recovery;

    localparam int CORDW = 10;
    localparam int LF    = 2;
    localparam int HT    = 40;
    localparam int HA    = 32;
    localparam int HS0   = 34;
    localparam int HS1   = 38;
    localparam int VA    = 16;
    localparam int VS0   = 17;
    localparam int VS1   = 19;
    localparam int VT    = 20;
    localparam int SAT   = 1023;

    logic             clk_pix, rst_n, hsync, vsync, de;
    logic [CORDW-1:0] sx, sy, h_total, v_total, h_active, v_active;
    logic             de_o, locked, err;

    display_timing_recovery #(.CORDW(CORDW), .LOCK_FRAMES(LF)) dut (
        .clk_pix(clk_pix), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .de(de),
        .sx(sx), .sy(sy), .de_o(de_o), .locked(locked), .err(err),
        .h_total(h_total), .v_total(v_total), .h_active(h_active), .v_active(v_active)
    );

    initial clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: frame-level view of the stream
    int s, t_f, hlast, nh, nf, run, last_gh, last_gv, lock_h, lock_v, p_ht, p_vt;
    bit exp_locked, exp_err, pend, p_full, vseen, prev_h, prev_v;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        exp_locked = 0; exp_err = 0; pend = 0; vseen = 0;
        nf = 0; run = 0; nh = 0; hlast = 0; t_f = s;
        prev_h = 1; prev_v = 1;
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_sx", sx, 0);
        check_eq("rst_sy", sy, 0);
        check_eq("rst_de_o", de_o, 0);
        check_eq("rst_locked", locked, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_h_total", h_total, 0);
        check_eq("rst_v_total", v_total, 0);
        check_eq("rst_h_active", h_active, 0);
        check_eq("rst_v_active", v_active, 0);
        model_reset();
        #1 rst_n = 1'b1;
    endtask

    task automatic step(input logic h, input logic v, input logic d, input int x, input int y);
        int hc, gh;
        bit fh, fv, to, fail;
        hsync = h; vsync = v; de = d;
        @(posedge clk_pix); #1;
        s++;
        check_eq("de_o", de_o, d);
        if (d && vseen) begin
            check_eq("sx", sx, x);
            check_eq("sy", sy, y);
        end
        check_eq("locked", locked, exp_locked);
        check_eq("err", err, exp_err);
        if (pend) begin
            check_eq("h_total", h_total, p_ht);
            check_eq("v_total", v_total, p_vt);
            if (p_full) begin
                check_eq("h_active", h_active, HA);
                check_eq("v_active", v_active, VA);
            end
            pend = 0;
        end
        fh = prev_h && !h;
        fv = prev_v && !v;
        prev_h = h; prev_v = v;
        hc = s - t_f;
        if (hc > SAT) hc = SAT;
        to = (hc == SAT);
        gh = fh ? hc : hlast;
        exp_err = 0;
        fail = exp_locked && (to || (fh && hc != lock_h) || (fv && (gh != lock_h || nh != lock_v)));
        if (fail) begin
            exp_err = 1; exp_locked = 0; nf = 0; run = 0;
        end else if (!exp_locked && nf > 0 && to) begin
            nf = 0; run = 0;
        end else if (fv && !exp_locked) begin
            if (nf == 0) nf = 1;
            else begin
                if (run > 0 && gh == last_gh && nh == last_gv) run++;
                else run = 1;
                last_gh = gh; last_gv = nh;
                if (run == LF + 1) begin
                    exp_locked = 1; lock_h = gh; lock_v = nh;
                end
            end
        end
        if (fv) begin
            pend = 1; p_ht = gh; p_vt = nh; p_full = vseen; vseen = 1;
            nh = fh ? 1 : 0;
        end else if (fh && nh < SAT) nh++;
        if (fh) begin hlast = hc; t_f = s; end
    endtask

    task automatic run_frame(input int vt, input int long_y, input int hold_y, input int rst_y);
        for (int y = 0; y < vt; y++) begin
            int hl;
            hl = (y == long_y) ? HT + 1 : (y == hold_y) ? 1100 : HT;
            for (int x = 0; x < hl; x++) begin
                logic h, v, d;
                h = !(x >= HS0 && x < HS1 && y != hold_y);
                v = !(y >= VS0 && y < VS1);
                d = (x < HA && y < VA);
                step(h, v, d, x, y);
                if (y == rst_y && x == HA / 2) do_reset();
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; hsync = 1'b1; vsync = 1'b1; de = 1'b0; s = 0;
        repeat (2) @(posedge clk_pix);
        #1;
        do_reset();
        for (int f = 0; f < 6; f++) run_frame(VT, -1, -1, -1);
        run_frame(VT, $urandom_range(0, VT - 1), -1, -1);
        for (int f = 0; f < 5; f++) run_frame(VT, -1, -1, -1);
        run_frame(VT, -1, $urandom_range(VA, VT - 1), -1);
        for (int f = 0; f < 5; f++) run_frame(VT, -1, -1, -1);
        run_frame(VT, -1, -1, $urandom_range(0, VT - 1));
        for (int f = 0; f < 5; f++) run_frame(VT, -1, -1, -1);
        do_reset();
        for (int f = 0; f < 6; f++) run_frame((f % 2) ? VT + 1 : VT, -1, -1, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
